sqr_rem: RTL

Iterative shift-add squaring unit that rebuilds a radicand from a root/remainder pair: `dout = root*root + rem`. It is the inverse companion of the multi-cycle integer square-root unit in the same arithmetic library. It is used to reconstruct values after root-domain processing and to self-check sqrt results in-system. It shares that unit's port widths, so a sqrt output pair connects directly.

---
 rtl/sqr_rem.sv | 89 ++++++++
 1 files changed

// File: rtl/sqr_rem.sv
// sqr_rem: iterative shift-add squaring, dout = root*root + rem over H clocks.
// Defining SQR_REM_CHECK_EN adds rem_ok_o, flagging rem <= 2*root (legal sqrt remainder).
module sqr_rem #(
    parameter int DW = 32,
    localparam int DIN_W = DW + DW % 2,
    localparam int H = DIN_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [H-1:0]     root_i,
    input  logic [DW-2:0]    rem_i,
    input  logic             din_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DIN_W-1:0] dout_o,
    output logic             ovf_o
`ifdef SQR_REM_CHECK_EN
    ,
    output logic             rem_ok_o
`endif
);
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [DIN_W:0]   acc, acc_nxt;
    logic [DIN_W-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    assign busy_o = (state == RUN);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        accept    = (state == IDLE) && din_valid_i;
        last      = (state == RUN) && (cnt == '0);
        state_nxt = accept ? RUN : last ? IDLE : state;
        acc_nxt   = mplier[0] ? acc + {1'b0, mcand} : acc;
    end

    // The final edge stores the sum including the last partial product
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            done_o <= 1'b0;
            dout_o <= '0;
            ovf_o  <= 1'b0;
        end else begin
            done_o <= last;
            if (accept) begin
                acc    <= (DIN_W + 1)'(rem_i);
                mcand  <= DIN_W'(root_i);
                mplier <= root_i;
                cnt    <= CW'(H - 1);
            end else if (busy_o) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end
            if (last) begin
                dout_o <= acc_nxt[DIN_W-1:0];
                ovf_o  <= acc_nxt[DIN_W];
            end
        end

`ifdef SQR_REM_CHECK_EN
    localparam int CMPW = (DW - 1 > H + 1) ? DW - 1 : H + 1;

    logic ok_cap;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ok_cap   <= 1'b0;
            rem_ok_o <= 1'b0;
        end else begin
            if (accept) ok_cap <= (CMPW'(rem_i) <= CMPW'({root_i, 1'b0}));
            if (last) rem_ok_o <= ok_cap;
        end
`endif
endmodule
